// File: rtl/dds_pkg.sv
// Shared types and default widths for the polyphonic DDS.
package dds_pkg;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_READ  = 2'd1,
        S_ADD   = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam int DEF_ACC_W   = 32;
    localparam int DEF_PHASE_W = 10;

endpackage

// File: rtl/dds_voice_seq.sv
// Voice sequencer: one clear sweep after reset, then READ/ADD/WRITE per voice.
//   state   | meaning
//   S_CLEAR | zero one voice's memories per cycle, writes refused
//   S_READ  | latch operands of the current voice; holds while run=0
//   S_ADD   | form the next accumulator value
//   S_WRITE | write back, emit output, advance to the next voice
module dds_voice_seq
    import dds_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int VOICE_W    = $clog2(NUM_VOICES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic [VOICE_W-1:0] voice,
    output logic [VOICE_W-1:0] clear_idx,
    output logic               clear_en,
    output logic               latch_en,
    output logic               add_en,
    output logic               wb_en,
    output logic               wr_ready
);

    localparam logic [VOICE_W-1:0] LAST = VOICE_W'(NUM_VOICES - 1);

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_CLEAR;
            clear_idx <= '0;
            voice     <= '0;
        end else begin
            state <= state_nxt;
            if (clear_en) begin
                clear_idx <= (clear_idx == LAST) ? '0 : clear_idx + 1'b1;
            end
            if (wb_en) begin
                voice <= (voice == LAST) ? '0 : voice + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: state_nxt = (clear_idx == LAST) ? S_READ : S_CLEAR;
            S_READ:  state_nxt = run ? S_ADD : S_READ;
            S_ADD:   state_nxt = S_WRITE;
            S_WRITE: state_nxt = S_READ;
            default: state_nxt = S_CLEAR;
        endcase
    end

    always_comb begin
        clear_en = 1'b0;
        latch_en = 1'b0;
        add_en   = 1'b0;
        wb_en    = 1'b0;
        wr_ready = 1'b1;
        case (state)
            S_CLEAR: begin
                clear_en = 1'b1;
                wr_ready = 1'b0;
            end
            S_READ:  latch_en = run;
            S_ADD:   add_en   = 1'b1;
            S_WRITE: wb_en    = 1'b1;
            default: wr_ready = 1'b0;
        endcase
    end

endmodule

// File: rtl/dds_poly.sv
// Time-multiplexed polyphonic phase accumulator: one shared adder serves all
// voices, each voice updated once per 3*NUM_VOICES-cycle frame.
module dds_poly
    import dds_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int PHASE_W    = DEF_PHASE_W,
    parameter int VOICE_W    = $clog2(NUM_VOICES)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_run,
    input  logic               i_wr_valid,
    input  logic [VOICE_W-1:0] i_wr_voice,
    input  logic [ACC_W-1:0]   i_wr_tuning,
    input  logic               i_wr_enable,
    input  logic               i_wr_sync,
    output logic               o_wr_ready,
    output logic               o_valid,
    output logic [VOICE_W-1:0] o_voice,
    output logic [PHASE_W-1:0] o_phase,
    output logic               o_frame_end
);

    localparam logic [VOICE_W:0]   VOICE_COUNT = (VOICE_W + 1)'(NUM_VOICES);
    localparam logic [VOICE_W-1:0] LAST        = VOICE_W'(NUM_VOICES - 1);

    logic [VOICE_W-1:0] voice;
    logic [VOICE_W-1:0] clear_idx;
    logic               clear_en;
    logic               latch_en;
    logic               add_en;
    logic               wb_en;
    logic               wr_ready;

    dds_voice_seq #(
        .NUM_VOICES(NUM_VOICES),
        .VOICE_W   (VOICE_W)
    ) u_seq (
        .clk      (i_clk),
        .reset    (i_reset),
        .run      (i_run),
        .voice    (voice),
        .clear_idx(clear_idx),
        .clear_en (clear_en),
        .latch_en (latch_en),
        .add_en   (add_en),
        .wb_en    (wb_en),
        .wr_ready (wr_ready)
    );

    logic [ACC_W-1:0]      acc_mem    [NUM_VOICES];
    logic [ACC_W-1:0]      tuning_mem [NUM_VOICES];
    logic [NUM_VOICES-1:0] en_mem;

    logic [ACC_W-1:0] acc_op;
    logic [ACC_W-1:0] tuning_op;
    logic             en_op;
    logic [ACC_W-1:0] sum;

    logic accept;
    logic wr_hit;
    logic sync_hit;
    logic kill_q;
    logic kill;

    assign o_wr_ready = wr_ready & ~i_reset;
    assign accept     = i_wr_valid & o_wr_ready & ({1'b0, i_wr_voice} < VOICE_COUNT);
    assign wr_hit     = accept & (i_wr_voice == voice);
    assign sync_hit   = wr_hit & i_wr_sync;
    assign kill       = kill_q | sync_hit;

    // A sync to the in-flight voice cannot touch acc_mem (its operands are
    // already latched), so it is remembered and applied at writeback.
    always_ff @(posedge i_clk) begin
        if (clear_en) begin
            acc_mem[clear_idx]    <= '0;
            tuning_mem[clear_idx] <= '0;
            en_mem[clear_idx]     <= 1'b0;
        end
        if (accept) begin
            tuning_mem[i_wr_voice] <= i_wr_tuning;
            en_mem[i_wr_voice]     <= i_wr_enable;
            if (i_wr_sync && !wr_hit) begin
                acc_mem[i_wr_voice] <= '0;
            end
        end
        if (wb_en) begin
            acc_mem[voice] <= kill ? '0 : sum;
        end
    end

    always_ff @(posedge i_clk) begin
        if (latch_en) begin
            acc_op    <= acc_mem[voice];
            tuning_op <= tuning_mem[voice];
            en_op     <= en_mem[voice];
        end
        if (add_en) begin
            sum <= en_op ? acc_op + tuning_op : acc_op;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            kill_q <= 1'b0;
        end else if (wb_en) begin
            kill_q <= 1'b0;
        end else if (sync_hit) begin
            kill_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid     <= 1'b0;
            o_frame_end <= 1'b0;
            o_voice     <= '0;
            o_phase     <= '0;
        end else begin
            o_valid     <= wb_en;
            o_frame_end <= wb_en && (voice == LAST);
            if (wb_en) begin
                o_voice <= voice;
                o_phase <= kill ? '0 : sum[ACC_W-1 -: PHASE_W];
            end
        end
    end

endmodule

// File: tb/tb_dds_poly.sv
// Bench for dds_poly (4 voices): directed scenarios plus random writes/stalls
// checked against a per-voice frame-level accumulator model.
module tb_dds_poly;

    localparam int NV = 4;
    localparam int AW = 32;
    localparam int PW = 10;
    localparam int VW = 2;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          run       = 1'b1;
    logic          wr_valid  = 1'b0;
    logic [VW-1:0] wr_voice  = '0;
    logic [AW-1:0] wr_tuning = '0;
    logic          wr_enable = 1'b0;
    logic          wr_sync   = 1'b0;
    logic          wr_ready;
    logic          valid;
    logic [VW-1:0] voice;
    logic [PW-1:0] phase;
    logic          frame_end;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_v   = NV - 1;

    logic [AW-1:0] m_acc  [NV];
    logic [AW-1:0] m_tun  [NV];
    logic [AW-1:0] m_dtun [NV];
    logic          m_en   [NV];
    logic          m_den  [NV];
    logic          m_kill [NV];
    logic          m_dpend[NV];

    always #5 clk = ~clk;

    dds_poly #(.NUM_VOICES(NV), .ACC_W(AW), .PHASE_W(PW)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_run      (run),
        .i_wr_valid (wr_valid),
        .i_wr_voice (wr_voice),
        .i_wr_tuning(wr_tuning),
        .i_wr_enable(wr_enable),
        .i_wr_sync  (wr_sync),
        .o_wr_ready (wr_ready),
        .o_valid    (valid),
        .o_voice    (voice),
        .o_phase    (phase),
        .o_frame_end(frame_end)
    );

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_acc[i]   = '0;
            m_tun[i]   = '0;
            m_dtun[i]  = '0;
            m_en[i]    = 1'b0;
            m_den[i]   = 1'b0;
            m_kill[i]  = 1'b0;
            m_dpend[i] = 1'b0;
        end
        last_v = NV - 1;
    endtask

    // Phase voice v emits this frame; advances the model by one voice update.
    task automatic model_out(input int v, output logic [31:0] ph);
        if (m_kill[v]) m_acc[v] = '0;
        else if (m_en[v]) m_acc[v] = m_acc[v] + m_tun[v];
        ph = 32'(m_acc[v] >> (AW - PW));
        m_kill[v] = 1'b0;
        if (m_dpend[v]) begin
            m_tun[v]   = m_dtun[v];
            m_en[v]    = m_den[v];
            m_dpend[v] = 1'b0;
        end
        last_v = v;
    endtask

    // Drive one accepted write for the next edge; the in-flight voice is the
    // one after the last emitted voice, and its new settings wait a frame.
    task automatic drive_write(input int w, input logic [AW-1:0] tun, input logic en, input logic sync);
        wr_valid  = 1'b1;
        wr_voice  = VW'(w);
        wr_tuning = tun;
        wr_enable = en;
        wr_sync   = sync;
        if (w == (last_v + 1) % NV) begin
            m_dtun[w]  = tun;
            m_den[w]   = en;
            m_dpend[w] = 1'b1;
            if (sync) m_kill[w] = 1'b1;
        end else begin
            m_tun[w] = tun;
            m_en[w]  = en;
            if (sync) m_acc[w] = '0;
        end
    endtask

    task automatic step(output logic vld, output logic [31:0] gv, output logic [31:0] gp,
                        output logic gfe, output int ev, output logic [31:0] ep);
        @(negedge clk);
        cyc++;
        wr_valid = 1'b0;
        wr_sync  = 1'b0;
        vld = valid;
        gv  = 32'(voice);
        gp  = 32'(phase);
        gfe = frame_end;
        ev  = (last_v + 1) % NV;
        ep  = '0;
        if (vld === 1'b1) model_out(ev, ep);
    endtask

    task automatic test_reset();
        logic vld, gfe;
        logic [31:0] gv, gp, ep;
        int ev;
        reset = 1'b1;
        run   = 1'b1;
        drive_write(2, 32'h1234_5678, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || frame_end !== 1'b0 || voice !== '0 || phase !== '0 || wr_ready !== 1'b0)
            $display("FAIL reset_outputs: valid=%b fe=%b voice=%0d phase=%0d ready=%b, want all 0",
                     valid, frame_end, voice, phase, wr_ready);
        else n_pass++;
        reset = 1'b0;
        model_reset();
        cyc = 0;
        wr_valid  = 1'b1;
        wr_voice  = '0;
        wr_tuning = 32'h4000_0000;
        #1;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) begin
                @(negedge clk);
                cyc++;
            end
            n_checks++;
            if (wr_ready !== (c >= 4) || valid !== 1'b0)
                $display("FAIL clear_ready cycle %0d: ready=%b valid=%b, want ready=%0d valid=0",
                         c, wr_ready, valid, (c >= 4));
            else n_pass++;
            wr_valid = (c <= 3);
        end
        step(vld, gv, gp, gfe, ev, ep);
        n_checks++;
        if (vld !== 1'b1 || gv !== 0 || gp !== 0)
            $display("FAIL first_output cycle %0d: valid=%b voice=%0d phase=%0d, want 1/0/0", cyc, vld, gv, gp);
        else n_pass++;
        repeat (9) begin
            step(vld, gv, gp, gfe, ev, ep);
            n_checks++;
            if (vld !== ((cyc - 7) % 3 == 0) ||
                (vld === 1'b1 && (gv !== ev || gp !== 0 || gfe !== (ev == NV - 1))))
                $display("FAIL first_frame cycle %0d: valid=%b voice=%0d phase=%0d fe=%b, want voice %0d phase 0",
                         cyc, vld, gv, gp, gfe, ev);
            else n_pass++;
        end
    endtask

    task automatic test_tune_step();
        logic vld, gfe;
        logic [31:0] gv, gp, ep;
        int ev, k, prev;
        k = 0;
        prev = 0;
        drive_write(1, 32'h0040_0000, 1'b1, 1'b0);
        repeat (36) begin
            step(vld, gv, gp, gfe, ev, ep);
            if (vld === 1'b1) begin
                n_checks++;
                if (gv !== ev || gp !== ep || gfe !== (ev == NV - 1) || (ev != 1 && gp !== 0))
                    $display("FAIL tune_step cycle %0d: voice=%0d phase=%0d fe=%b, want voice %0d phase %0d",
                             cyc, gv, gp, gfe, ev, ep);
                else n_pass++;
                if (ev == 1) begin
                    k++;
                    n_checks++;
                    if (gp !== 32'(k) || (k > 1 && cyc - prev != 12))
                        $display("FAIL tune_v1_increment cycle %0d: phase=%0d gap=%0d, want phase %0d gap 12",
                                 cyc, gp, cyc - prev, k);
                    else n_pass++;
                    prev = cyc;
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic vld, gfe;
        logic [31:0] gv, gp, ep;
        int ev, k;
        int wrap_exp [3] = '{512, 0, 512};
        k = 0;
        drive_write(2, 32'h8000_0000, 1'b1, 1'b0);
        repeat (36) begin
            step(vld, gv, gp, gfe, ev, ep);
            if (vld === 1'b1) begin
                n_checks++;
                if (gv !== ev || gp !== ep || gfe !== (ev == NV - 1))
                    $display("FAIL wrap_model cycle %0d: voice=%0d phase=%0d, want voice %0d phase %0d",
                             cyc, gv, gp, ev, ep);
                else n_pass++;
                if (ev == 2 && k < 3) begin
                    n_checks++;
                    if (gp !== 32'(wrap_exp[k]))
                        $display("FAIL wrap_alternate frame %0d: phase=%0d, want %0d", k, gp, wrap_exp[k]);
                    else n_pass++;
                    k++;
                end
            end
        end
    endtask

    task automatic test_sync_inflight();
        logic vld, gfe;
        logic [31:0] gv, gp, ep;
        int ev, k;
        bit found;
        int sync_exp [2] = '{0, 4};
        found = 1'b0;
        k = 0;
        drive_write(2, 32'h0100_0000, 1'b1, 1'b0);
        for (int i = 0; i < 12 && !found; i++) begin
            step(vld, gv, gp, gfe, ev, ep);
            if (vld === 1'b1) begin
                n_checks++;
                if (gv !== ev || gp !== ep)
                    $display("FAIL sync_pre cycle %0d: voice=%0d phase=%0d, want voice %0d phase %0d",
                             cyc, gv, gp, ev, ep);
                else n_pass++;
                if (ev == 1) found = 1'b1;
            end
        end
        n_checks++;
        if (!found) $display("FAIL sync_wait: voice 1 output seen=0, want 1 within 12 cycles");
        else n_pass++;
        step(vld, gv, gp, gfe, ev, ep);
        drive_write(2, 32'h0100_0000, 1'b1, 1'b1);
        repeat (15) begin
            step(vld, gv, gp, gfe, ev, ep);
            if (vld === 1'b1) begin
                n_checks++;
                if (gv !== ev || gp !== ep || gfe !== (ev == NV - 1))
                    $display("FAIL sync_model cycle %0d: voice=%0d phase=%0d, want voice %0d phase %0d",
                             cyc, gv, gp, ev, ep);
                else n_pass++;
                if (ev == 2 && k < 2) begin
                    n_checks++;
                    if (gp !== 32'(sync_exp[k]))
                        $display("FAIL sync_inflight frame %0d: phase=%0d, want %0d", k, gp, sync_exp[k]);
                    else n_pass++;
                    k++;
                end
            end
        end
    endtask

    task automatic test_stall();
        logic vld, gfe;
        logic [31:0] gv, gp, ep;
        int ev, seen;
        logic [PW-1:0] frozen;
        bit found, moved;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(vld, gv, gp, gfe, ev, ep);
            if (vld === 1'b1) begin
                found = 1'b1;
                n_checks++;
                if (gv !== ev || gp !== ep)
                    $display("FAIL stall_pre cycle %0d: voice=%0d phase=%0d, want voice %0d phase %0d",
                             cyc, gv, gp, ev, ep);
                else n_pass++;
            end
        end
        run = 1'b0;
        frozen = phase;
        seen = 0;
        moved = 1'b0;
        repeat (30) begin
            step(vld, gv, gp, gfe, ev, ep);
            if (vld !== 1'b0) seen++;
            if (gp !== 32'(frozen)) moved = 1'b1;
        end
        n_checks++;
        if (seen != 0 || moved)
            $display("FAIL stall_hold: valids=%0d phase_moved=%0d, want 0/0", seen, moved);
        else n_pass++;
        run = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            step(vld, gv, gp, gfe, ev, ep);
            n_checks++;
            if (vld !== (i % 3 == 0) || (vld === 1'b1 && (gv !== ev || gp !== ep)))
                $display("FAIL stall_resume step %0d: valid=%b voice=%0d phase=%0d, want valid=%0d voice %0d phase %0d",
                         i, vld, gv, gp, (i % 3 == 0), ev, ep);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic vld, gfe;
        logic [31:0] gv, gp, ep;
        int ev;
        repeat (2) step(vld, gv, gp, gfe, ev, ep);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || voice !== '0 || phase !== '0 || wr_ready !== 1'b0)
            $display("FAIL reset_mid_outputs: valid=%b voice=%0d phase=%0d ready=%b, want all 0",
                     valid, voice, phase, wr_ready);
        else n_pass++;
        reset = 1'b0;
        model_reset();
        cyc = 0;
        #1;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) begin
                @(negedge clk);
                cyc++;
            end
            n_checks++;
            if (wr_ready !== (c >= 4) || valid !== 1'b0)
                $display("FAIL reset_mid_clear cycle %0d: ready=%b valid=%b, want ready=%0d valid=0",
                         c, wr_ready, valid, (c >= 4));
            else n_pass++;
        end
        repeat (26) begin
            step(vld, gv, gp, gfe, ev, ep);
            n_checks++;
            if (vld !== (cyc >= 7 && (cyc - 7) % 3 == 0) ||
                (vld === 1'b1 && (gv !== ev || gp !== 0 || ep !== 0)))
                $display("FAIL reset_mid_zero cycle %0d: valid=%b voice=%0d phase=%0d, want voice %0d phase 0",
                         cyc, vld, gv, gp, ev);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic vld, gfe;
        logic [31:0] gv, gp, ep;
        int ev, w, outs;
        outs = 0;
        for (int i = 0; i < 900; i++) begin
            step(vld, gv, gp, gfe, ev, ep);
            if (vld === 1'b1) begin
                outs++;
                n_checks++;
                if (gv !== ev || gp !== ep || gfe !== (ev == NV - 1))
                    $display("FAIL random cycle %0d: voice=%0d phase=%0d fe=%b, want voice %0d phase %0d fe %0d",
                             cyc, gv, gp, gfe, ev, ep, (ev == NV - 1));
                else n_pass++;
            end
            run = ($urandom_range(3) != 0);
            if ($urandom_range(2) == 0) begin
                w = int'($urandom_range(NV - 1));
                if (w == (last_v + 1) % NV) run = 1'b1;
                drive_write(w, $urandom, 1'($urandom_range(1)), ($urandom_range(3) == 0));
            end
        end
        run = 1'b1;
        n_checks++;
        if (outs < 100) $display("FAIL random_activity: outputs=%0d, want at least 100", outs);
        else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_tune_step();
        test_wrap();
        test_sync_inflight();
        test_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
